// File: rtl/axi4_lite_master_bridge.sv
// axi4_lite_master_bridge: single-outstanding command/response to AXI4-Lite master
// Define AXI_MASTER_TIMEOUT_EN to add the response watchdog, sticky timeout flag and DRAIN state.
module axi4_lite_master_bridge
`ifdef AXI_MASTER_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 1024)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_resp,
  output logic        rsp_write,
`ifdef AXI_MASTER_TIMEOUT_EN
  output logic        timeout,
`endif
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);
  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
`ifdef AXI_MASTER_TIMEOUT_EN
    , DRAIN
`endif
  } state_t;
  state_t state;
`ifdef AXI_MASTER_TIMEOUT_EN
  logic [31:0] cnt;
  logic        drain;
`endif
  assign awprot = 3'b000;
  assign arprot = 3'b000;
  // Transaction sequencer with all interface outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_resp  <= '0;
      rsp_write <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      timeout   <= 1'b0;
      cnt       <= '0;
      drain     <= 1'b0;
`endif
    end else begin
      cmd_ready <= (state == IDLE) && !(cmd_valid && cmd_ready);
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          if (cmd_write) begin
            awaddr  <= cmd_addr;
            wdata   <= cmd_wdata;
            wstrb   <= cmd_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= WR_ADDR_DATA;
          end else begin
            araddr  <= cmd_addr;
            arvalid <= 1'b1;
            state   <= RD_ADDR;
          end
        end
        WR_ADDR_DATA: begin
          awvalid <= awvalid && !awready;
          wvalid  <= wvalid && !wready;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
`ifdef AXI_MASTER_TIMEOUT_EN
            cnt    <= '0;
`endif
          end
        end
        RD_ADDR: if (arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          state   <= RD_DATA;
`ifdef AXI_MASTER_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        WR_RESP, RD_DATA: begin
          if (state == WR_RESP ? bvalid : rvalid) begin
            rsp_resp  <= state == WR_RESP ? bresp : rresp;
            rsp_data  <= state == WR_RESP ? 32'h0 : rdata;
            rsp_write <= state == WR_RESP;
            rsp_valid <= 1'b1;
            bready    <= 1'b0;
            rready    <= 1'b0;
            state     <= RESP;
          end
`ifdef AXI_MASTER_TIMEOUT_EN
          else if (cnt == TIMEOUT_CYCLES - 1) begin
            rsp_resp  <= 2'b11;
            rsp_data  <= '0;
            rsp_write <= state == WR_RESP;
            rsp_valid <= 1'b1;
            bready    <= 1'b0;
            rready    <= 1'b0;
            timeout   <= 1'b1;
            drain     <= 1'b1;
            state     <= RESP;
          end else cnt <= cnt + 32'd1;
`endif
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
`ifdef AXI_MASTER_TIMEOUT_EN
          if (drain) begin
            drain  <= 1'b0;
            bready <= 1'b1;
            rready <= 1'b1;
            state  <= DRAIN;
          end
`endif
        end
`ifdef AXI_MASTER_TIMEOUT_EN
        DRAIN: if (bvalid || rvalid) begin
          bready <= 1'b0;
          rready <= 1'b0;
          state  <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
